// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and
// instruction geometry constants.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUSY  = 3'd1,
    DRAIN = 3'd2,
    FULL  = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam int JT_W        = 26;

endpackage

// File: rtl/perf_ctr.sv
// Free-running wrapping event counter with synchronous reset and an
// increment enable.
module perf_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: reads one word per PC over a req/ack memory port,
// holds it in an IR for decode and returns PC+4 / jump target / PC write-enable.
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          pc_in,
  input  logic                       pc_valid,
  input  logic                       flush,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_ack,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic [DATA_W-1:0]          ir_out,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  output logic [ADDR_W-1:0]          pc_plus4,
  output logic [fetch_pkg::JT_W-1:0] jtarget,
  output logic                       pc_wen,
  output logic                       fault,
  output logic [CNT_W-1:0]           fetch_cnt
);

  import fetch_pkg::*;

  fetch_state_t      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              wen_q, wen_d;
  logic              fault_q, fault_d;
  logic              launch;
  logic              handoff;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    vld_d   = vld_q;
    pc4_d   = pc4_q;
    wen_d   = 1'b0;
    fault_d = fault_q;
    launch  = 1'b0;
    handoff = 1'b0;

    case (state_q)
      IDLE: begin
        if (pc_valid && !flush) launch = 1'b1;
      end
      BUSY: begin
        if (flush) begin
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          req_d   = 1'b0;
          ir_d    = imem_rdata;
          pc4_d   = addr_q + ADDR_W'(INSTR_BYTES);
          vld_d   = 1'b1;
          wen_d   = 1'b1;
          state_d = FULL;
        end
      end
      // A request already on the bus is never retracted; wait out its ack.
      DRAIN: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      FULL: begin
        if (flush) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end else if (ir_ready) begin
          handoff = 1'b1;
          vld_d   = 1'b0;
          state_d = IDLE;
          if (pc_valid) launch = 1'b1;
        end
      end
      FAULT: begin
        if (flush) begin
          fault_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      addr_d = pc_in;
      if (|pc_in[1:0]) begin
        fault_d = 1'b1;
        state_d = FAULT;
      end else begin
        req_d   = 1'b1;
        state_d = BUSY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ir_q    <= '0;
      vld_q   <= 1'b0;
      pc4_q   <= '0;
      wen_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
      pc4_q   <= pc4_d;
      wen_q   <= wen_d;
      fault_q <= fault_d;
    end
  end

  perf_ctr #(.CNT_W(CNT_W)) u_fetch_ctr (
    .clk (clk),
    .rst (rst),
    .inc (handoff),
    .cnt (fetch_cnt)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir_out    = ir_q;
  assign ir_valid  = vld_q;
  assign pc_plus4  = pc4_q;
  assign jtarget   = ir_q[JT_W-1:0];
  assign pc_wen    = wen_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory responder, transaction-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_inst_fetch;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = 8;
  localparam int CMOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst, pc_valid, flush, imem_ack, ir_ready;
  logic [AW-1:0] pc_in, imem_addr, pc_plus4;
  logic [DW-1:0] imem_rdata, ir_out;
  logic          imem_req, ir_valid, pc_wen, fault;
  logic [25:0]   jtarget;
  logic [CW-1:0] fetch_cnt;

  int vectors = 0;
  int errors  = 0;
  int mem_wait = 0;
  int wcnt = 0;
  int n_hand = 0;
  bit chk_en = 1'b0;

  bit          m_busy, m_drop, m_have, m_fault, m_wen;
  logic [31:0] m_addr, m_ir, m_pc4;
  int          m_cnt;

  always #5 clk = ~clk;

  inst_fetch #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir_out     (ir_out),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .pc_plus4   (pc_plus4),
    .jtarget    (jtarget),
    .pc_wen     (pc_wen),
    .fault      (fault),
    .fetch_cnt  (fetch_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0C00_0123;
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: acks after mem_wait idle request cycles, data is a function of address.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'hBAD0_BAD0;
      if (imem_req === 1'b1 && rst === 1'b0) begin
        if (wcnt >= mem_wait) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wcnt       = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task m_start(input logic [31:0] a);
    m_addr = a;
    if (a[1:0] != 2'b00) m_fault = 1'b1;
    else                 m_busy  = 1'b1;
  endtask

  // Reference model: what the stage must hold after each rising edge.
  always @(posedge clk) begin
    m_wen = 1'b0;
    if (rst) begin
      m_busy = 0; m_drop = 0; m_have = 0; m_fault = 0;
      m_addr = '0; m_ir = '0; m_pc4 = '0; m_cnt = 0;
    end else if (m_fault) begin
      if (flush) m_fault = 1'b0;
    end else if (m_busy) begin
      if (imem_ack) begin
        m_busy = 1'b0;
        if (!m_drop && !flush) begin
          m_have = 1'b1;
          m_ir   = imem_rdata;
          m_pc4  = m_addr + 32'd4;
          m_wen  = 1'b1;
        end
        m_drop = 1'b0;
      end else if (flush) begin
        m_drop = 1'b1;
      end
    end else if (m_have) begin
      if (flush) m_have = 1'b0;
      else if (ir_ready) begin
        m_have = 1'b0;
        m_cnt++;
        if (pc_valid) m_start(pc_in);
      end
    end else if (pc_valid && !flush) begin
      m_start(pc_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("imem_req", imem_req, m_busy);
      if (m_busy) chk("imem_addr", imem_addr, m_addr);
      chk1("ir_valid", ir_valid, m_have);
      if (m_have) begin
        chk("ir_out", ir_out, m_ir);
        chk("pc_plus4", pc_plus4, m_pc4);
        chk("jtarget", 32'(jtarget), 32'(m_ir[25:0]));
      end
      chk1("pc_wen", pc_wen, m_wen);
      chk1("fault", fault, m_fault);
      chk("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt % CMOD));
    end
  end

  task automatic wait_ir(input int lim);
    int n = 0;
    while (ir_valid !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk1("ir_valid wait", ir_valid, 1'b1);
  endtask

  task automatic fetch_one(input logic [31:0] a);
    pc_in = a; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    wait_ir(20);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    n_hand++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ir_hold;
    rst = 1'b1; pc_in = '0; pc_valid = 1'b0; flush = 1'b0; ir_ready = 1'b0;
    repeat (2) tick();
    chk_en = 1'b1;
    chk1("rst imem_req", imem_req, 1'b0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst ir_out", ir_out, 32'h0);
    chk1("rst ir_valid", ir_valid, 1'b0);
    chk("rst fetch_cnt", 32'(fetch_cnt), 32'h0);
    rst = 1'b0;
    tick();

    // 1: zero-wait fetch from PC 0
    mem_wait = 0;
    pc_in = 32'h0; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk1("t1 req at N+1", imem_req, 1'b1);
    chk1("t1 ir_valid at N+1", ir_valid, 1'b0);
    tick();
    chk1("t1 ir_valid at N+2", ir_valid, 1'b1);
    chk("t1 ir_out", ir_out, 32'h0C00_0123);
    chk("t1 pc_plus4", pc_plus4, 32'h4);
    chk("t1 jtarget", 32'(jtarget), 32'h0000123);
    chk1("t1 pc_wen pulse", pc_wen, 1'b1);
    tick();
    chk1("t1 pc_wen drops", pc_wen, 1'b0);
    chk1("t1 ir_valid held", ir_valid, 1'b1);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    n_hand++;
    chk("t1 fetch_cnt", 32'(fetch_cnt), 32'd1);

    // 2: three wait cycles, then IR held while decode stalls
    mem_wait = 3;
    pc_in = 32'h0001_1220; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("t2 req held", imem_req, 1'b1);
      chk("t2 addr held", imem_addr, 32'h0001_1220);
      chk1("t2 not valid yet", ir_valid, 1'b0);
      tick();
    end
    chk1("t2 ir_valid after ack", ir_valid, 1'b1);
    chk("t2 ir_out", ir_out, 32'hDEAC_1220);
    chk("t2 pc_plus4", pc_plus4, 32'h0001_1224);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2 ir stable", ir_out, 32'hDEAC_1220);
      chk("t2 cnt stable", 32'(fetch_cnt), 32'd1);
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    n_hand++;
    chk("t2 fetch_cnt", 32'(fetch_cnt), 32'd2);

    // 3: flush two cycles before ack drains the request
    pc_in = 32'h0000_0100; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("t3 req kept in drain", imem_req, 1'b1);
    chk("t3 addr kept", imem_addr, 32'h0000_0100);
    tick();
    chk1("t3 req still kept", imem_req, 1'b1);
    tick();
    chk1("t3 req released", imem_req, 1'b0);
    chk1("t3 no ir_valid", ir_valid, 1'b0);
    chk1("t3 no pc_wen", pc_wen, 1'b0);
    chk("t3 ir untouched", ir_out, 32'hDEAC_1220);
    tick();

    // 4: misaligned PC faults, flush recovers
    mem_wait = 0;
    pc_in = 32'h0001_1223; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk1("t4 fault", fault, 1'b1);
    chk1("t4 no req", imem_req, 1'b0);
    repeat (3) tick();
    chk1("t4 fault held", fault, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("t4 fault cleared", fault, 1'b0);
    fetch_one(32'h0000_0200);
    chk("t4 ir_out", ir_out, 32'hDEAD_0200);
    chk("t4 pc_plus4", pc_plus4, 32'h0000_0204);
    chk("t4 fetch_cnt", 32'(fetch_cnt), 32'(n_hand % CMOD));

    // 5a: PC+4 wraps
    fetch_one(32'hFFFF_FFFC);
    chk("t5 pc_plus4 wrap", pc_plus4, 32'h0);
    chk("t5 ir_out", ir_out, 32'h2152_FFFC);

    // Back-to-back stream: one handoff every two cycles
    pc_in = 32'h0000_0800; pc_valid = 1'b1; ir_ready = 1'b1;
    repeat (8) tick();
    chk("b2b count", 32'(fetch_cnt), 32'((n_hand + 3) % CMOD));
    chk1("b2b holding", ir_valid, 1'b1);
    pc_valid = 1'b0;
    tick();
    ir_ready = 1'b0;
    n_hand += 4;
    chk("b2b final count", 32'(fetch_cnt), 32'(n_hand % CMOD));

    // 5b: counter wrap
    while (n_hand % CMOD != CMOD - 1) fetch_one(32'h0000_1000 + 32'(n_hand * 4));
    chk("t5 cnt at max", 32'(fetch_cnt), 32'(CMOD - 1));
    fetch_one(32'h0000_2000);
    chk("t5 cnt wraps", 32'(fetch_cnt), 32'h0);

    // 6: flush beats ir_ready in FULL
    pc_in = 32'h0000_0300; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    wait_ir(20);
    ir_hold = 32'(fetch_cnt);
    flush = 1'b1; ir_ready = 1'b1;
    tick();
    flush = 1'b0; ir_ready = 1'b0;
    chk1("t6 ir_valid dropped", ir_valid, 1'b0);
    chk("t6 cnt unchanged", 32'(fetch_cnt), ir_hold);

    // 6b: reset while a request is outstanding
    fetch_one(32'h0000_0304);
    mem_wait = 3;
    pc_in = 32'h0000_0400; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    chk1("t6 req before rst", imem_req, 1'b1);
    rst = 1'b1;
    tick();
    chk1("t6 rst imem_req", imem_req, 1'b0);
    chk("t6 rst imem_addr", imem_addr, 32'h0);
    chk("t6 rst ir_out", ir_out, 32'h0);
    chk1("t6 rst ir_valid", ir_valid, 1'b0);
    chk("t6 rst pc_plus4", pc_plus4, 32'h0);
    chk("t6 rst jtarget", 32'(jtarget), 32'h0);
    chk1("t6 rst pc_wen", pc_wen, 1'b0);
    chk1("t6 rst fault", fault, 1'b0);
    chk("t6 rst fetch_cnt", 32'(fetch_cnt), 32'h0);
    rst = 1'b0;
    n_hand = 0;
    mem_wait = 0;
    fetch_one(32'h0000_0500);
    chk("t6 recover ir_out", ir_out, 32'hDEAD_0500);
    chk("t6 recover cnt", 32'(fetch_cnt), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
